// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer blocks.
//
// Contents:
//   DIV_W, SEL_W  default divider width and select width for clk_ena_gen
//   div_sel_e     encoded divider selects, shared with the timer
//                 control-register decode
package timer_pkg;

    localparam int DIV_W = 4;
    localparam int SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        SEL_DIV2  = 2'd0,
        SEL_DIV4  = 2'd1,
        SEL_DIV8  = 2'd2,
        SEL_DIV16 = 2'd3
    } div_sel_e;

endpackage : timer_pkg

// File: rtl/rise_detect.sv
// Registered rising-edge detector for the divider tap.
// Emits a one-cycle pulse in the cycle after the tap is seen going 0 -> 1.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   clr    in   synchronous clear of history and pulse (divider restart)
//   hold   in   freeze history; pulse is forced low while held
//   tap    in   selected divider bit
//   pulse  out  registered one-cycle strobe
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    input  logic tap,
    output logic pulse
);

    logic tap_d1_q, tap_d1_d;
    logic pulse_q, pulse_d;

    always_comb begin
        tap_d1_d = tap_d1_q;
        pulse_d  = 1'b0;
        if (clr) begin
            tap_d1_d = 1'b0;
        end else if (!hold) begin
            tap_d1_d = tap;
            pulse_d  = tap & ~tap_d1_q;
        end
        // While held the history is kept, so a tap rise that happened just
        // before the freeze is still detected once the divider resumes.
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_d1_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            tap_d1_q <= tap_d1_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule : rise_detect

// File: rtl/clk_ena_gen.sv
// Clock-enable generator for the 8-bit timer.
// Divides clk by 2^(k+1) (k = selected tap) and produces a one-cycle
// clk_ena strobe per divided period. Select changes and restarts reset the
// divider phase so no runt or double strobe can appear.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   enable   in   1 = divider runs, 0 = divider frozen (no strobes)
//   sel      in   tap select, division by 2^(sel+1); values >= DIV_W clamp
//   restart  in   one-cycle request to restart the divider phase
//   clk_ena  out  registered one-cycle strobe
//   div_cnt  out  current divider value (debug/status)
module clk_ena_gen
    import timer_pkg::*;
#(
    parameter int DIV_W_P = timer_pkg::DIV_W,
    parameter int SEL_W_P = timer_pkg::SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [SEL_W_P-1:0] sel,
    input  logic               restart,
    output logic               clk_ena,
    output logic [DIV_W_P-1:0] div_cnt
);

    if ((2 ** SEL_W_P) < DIV_W_P) begin : g_bad_param
        $error("clk_ena_gen: SEL_W_P too narrow for DIV_W_P taps");
    end

    logic [DIV_W_P-1:0] div_q, div_d;
    logic [SEL_W_P-1:0] sel_q, sel_d;
    logic [SEL_W_P-1:0] sel_idx;
    logic [DIV_W_P-1:0] tap_hit;
    logic               tap;
    logic               restart_evt;

    function automatic logic [SEL_W_P-1:0] clamp_sel(input logic [SEL_W_P-1:0] s);
        if (int'(s) >= DIV_W_P) begin
            return SEL_W_P'(DIV_W_P - 1);
        end
        return s;
    endfunction

    // A select change is treated exactly like an explicit restart, so the
    // new tap always starts from a clean phase.
    assign restart_evt = restart | (sel != sel_q);

    always_comb begin
        div_d = div_q;
        sel_d = sel_q;
        if (restart_evt) begin
            div_d = '0;
            sel_d = sel;
        end else if (enable) begin
            div_d = div_q + DIV_W_P'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            sel_q <= '0;
        end else begin
            div_q <= div_d;
            sel_q <= sel_d;
        end
    end

    // Tap mux: one-hot AND-OR over the divider bits.
    assign sel_idx = clamp_sel(sel_q);

    for (genvar gi = 0; gi < DIV_W_P; gi++) begin : g_tap
        assign tap_hit[gi] = (sel_idx == SEL_W_P'(gi)) & div_q[gi];
    end

    assign tap = |tap_hit;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst   (rst),
        .clr   (restart_evt),
        .hold  (~enable),
        .tap   (tap),
        .pulse (clk_ena)
    );

    assign div_cnt = div_q;

endmodule : clk_ena_gen

// File: tb/tb_clk_ena_gen.sv
// Self-checking bench for clk_ena_gen. A reference model counts run edges
// since the last reset/restart and derives strobe and divider value
// arithmetically from the strobe schedule.
module tb_clk_ena_gen;
    import timer_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             restart = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic             clk_ena;
    logic [DIV_W-1:0] div_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_run = 0;   // run edges since last reset/restart
    int m_sel = 0;   // select in force
    bit m_ena = 0;   // expected strobe

    int cyc = 0;
    int last_strobe = -1;
    int prev_strobe = -1;

    always #5 clk = ~clk;

    clk_ena_gen dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .sel     (sel),
        .restart (restart),
        .clk_ena (clk_ena),
        .div_cnt (div_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int tap_of(input int s);
        return (s >= DIV_W) ? DIV_W - 1 : s;
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_sel = 0;
        m_ena = 0;
    endtask

    // One clock transaction: drive at the falling edge, model at the rising
    // edge, compare at the next falling edge.
    task automatic step(input bit en, input int s, input bit rs);
        int p;
        enable  = en;
        sel     = SEL_W'(s);
        restart = rs;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (rs || (s != m_sel)) begin
            m_run = 0;
            m_ena = 0;
            m_sel = s;
        end else if (!en) begin
            m_ena = 0;
        end else begin
            m_run++;
            p = 2 << tap_of(m_sel);
            // tap bit rose on the previous run edge when (run-1) mod P == P/2
            m_ena = ((m_run - 1) % p) == (p / 2);
        end
        @(negedge clk);
        cyc++;
        check_val("clk_ena", 32'(clk_ena), 32'(m_ena));
        check_val("div_cnt", 32'(div_cnt), 32'(m_run % (1 << DIV_W)));
        if (clk_ena === 1'b1) begin
            prev_strobe = last_strobe;
            last_strobe = cyc;
        end
        $display("cyc=%0d rst=%0b en=%0b sel=%0d rs=%0b -> clk_ena=%0b div_cnt=%0d",
                 cyc, rst, en, s, rs, clk_ena, div_cnt);
    endtask

    initial begin
        @(negedge clk);
        // reset held 5 cycles
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, int'(SEL_DIV2), 1'b0);
        rst = 1'b0;

        // /2: strobes after edges 2, 4, 6
        for (int i = 0; i < 10; i++) step(1'b1, int'(SEL_DIV2), 1'b0);

        // /16 from reset, 64 cycles
        rst = 1'b1;
        step(1'b0, int'(SEL_DIV2), 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 65; i++) step(1'b1, int'(SEL_DIV16), 1'b0);

        // sel 0 -> 2 mid period
        for (int i = 0; i < 3; i++) step(1'b1, int'(SEL_DIV2), 1'b0);
        for (int i = 0; i < 24; i++) step(1'b1, int'(SEL_DIV8), 1'b0);

        // freeze 3 cycles with /4, just before a tap rise
        step(1'b1, int'(SEL_DIV4), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, int'(SEL_DIV4), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, int'(SEL_DIV4), 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, int'(SEL_DIV4), 1'b0);
        check_val("frz_period", 32'(last_strobe - prev_strobe), 32'd7);
        for (int i = 0; i < 6; i++) step(1'b1, int'(SEL_DIV4), 1'b0);

        // restart while frozen, then re-enable
        step(1'b0, int'(SEL_DIV4), 1'b1);
        step(1'b0, int'(SEL_DIV4), 1'b0);
        step(1'b0, int'(SEL_DIV4), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, int'(SEL_DIV4), 1'b0);

        // asynchronous reset while strobe is high
        begin
            int budget = 0;
            while (!(m_ena && clk_ena === 1'b1) && budget < 40) begin
                step(1'b1, int'(SEL_DIV4), 1'b0);
                budget++;
            end
            check_val("strobe_seen", 32'(budget < 40), 32'd1);
            #2 rst = 1'b1;
            #1;
            check_val("async_ena", 32'(clk_ena), 32'd0);
            check_val("async_div", 32'(div_cnt), 32'd0);
            model_reset();
            @(negedge clk);
            step(1'b1, int'(SEL_DIV2), 1'b0);
            rst = 1'b0;
        end

        // randomized traffic
        begin
            int s = int'(SEL_DIV2);
            for (int i = 0; i < 400; i++) begin
                bit en;
                bit rs;
                if ($urandom_range(0, 39) == 0) s = int'($urandom_range(0, 3));
                en = ($urandom_range(0, 7) != 0);
                rs = ($urandom_range(0, 31) == 0);
                step(en, s, rs);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_clk_ena_gen
